// File: rtl/op_pkg.sv
// Shared widths, opcodes, issue FSM states and op field layout for the
// op memory loader / issue path.
package op_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic [3:0] NOP_OP  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_MUL  = 4'h4;
    localparam logic [3:0] OP_MAC  = 4'h5;
    localparam logic [3:0] HALT_OP = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAPT,
        ISSUE,
        HALTED
    } issueState_t;

    typedef struct packed {
        logic [3:0] code;
        logic [3:0] dst;
        logic [3:0] srcA;
        logic [3:0] srcB;
    } op_fields_t;

endpackage

// File: rtl/op_issue_unit_ctr.sv
// Pending-op occupancy counter, 0..DEPTH, updated in the cycle of push/pop.
// No backpressure: a push while full with no pop is dropped and sets sticky overflow.
module op_occupancy_ctr
    import op_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            // a push in the clearing cycle is intentionally lost
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (full) overflow <= 1'b1;
                    else      count    <= count + 1'b1;
                end
                2'b01: begin
                    if (!empty) count <= count - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/op_issue_unit.sv
// Fetches committed ops from op memory (IDLE->REQ->CAPT->ISSUE, 3 edges to opValid, 1 op / 4 cycles).
// Holds opValid and fields until opReady; NOPs are dropped, HALT parks the FSM until resume.
module op_issue_unit
    import op_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] wCount,
    input  logic              opPush,
    output logic [ADDR_W-1:0] rCount,
    output logic              opRead,
    input  logic [DATA_W-1:0] opBus,
    input  logic              flush,
    input  logic              resume,
    output logic              opValid,
    input  logic              opReady,
    output logic [DATA_W-1:0] opWord,
    output logic [3:0]        opCode,
    output logic [3:0]        opDst,
    output logic [3:0]        opSrcA,
    output logic [3:0]        opSrcB,
    output logic [ADDR_W:0]   opCount,
    output logic              opEmpty,
    output logic              opFull,
    output logic              overflow,
    output logic              halted
);

    issueState_t       state, stateNxt;
    logic [ADDR_W-1:0] rCountNxt;
    logic [DATA_W-1:0] opWordNxt;
    logic              opReadNxt;
    logic              opValidNxt;
    logic              pop;
    op_fields_t        fields;

    assign fields = op_fields_t'(opWord);
    assign opCode = fields.code;
    assign opDst  = fields.dst;
    assign opSrcA = fields.srcA;
    assign opSrcB = fields.srcB;
    assign halted = (state == HALTED);

    op_occupancy_ctr u_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (opPush),
        .pop      (pop),
        .clear    (flush),
        .count    (opCount),
        .empty    (opEmpty),
        .full     (opFull),
        .overflow (overflow)
    );

    always_comb begin
        stateNxt   = state;
        rCountNxt  = rCount;
        opWordNxt  = opWord;
        opReadNxt  = 1'b0;
        opValidNxt = opValid;
        pop        = 1'b0;
        if (flush) begin
            // realign the read pointer with the loader and drop everything in flight
            stateNxt   = IDLE;
            rCountNxt  = wCount;
            opValidNxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!opEmpty) begin
                        stateNxt  = REQ;
                        opReadNxt = 1'b1;
                    end
                end
                REQ: stateNxt = CAPT;
                CAPT: begin
                    opWordNxt = opBus;
                    rCountNxt = rCount + 1'b1;
                    pop       = 1'b1;
                    if (opBus[DATA_W-1 -: 4] == NOP_OP) begin
                        stateNxt = IDLE;
                    end else begin
                        stateNxt   = ISSUE;
                        opValidNxt = 1'b1;
                    end
                end
                ISSUE: begin
                    if (opValid && opReady) begin
                        opValidNxt = 1'b0;
                        stateNxt   = (fields.code == HALT_OP) ? HALTED : IDLE;
                    end
                end
                HALTED: if (resume) stateNxt = IDLE;
                default: stateNxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rCount  <= '0;
            opRead  <= 1'b0;
            opWord  <= '0;
            opValid <= 1'b0;
        end else begin
            state   <= stateNxt;
            rCount  <= rCountNxt;
            opRead  <= opReadNxt;
            opWord  <= opWordNxt;
            opValid <= opValidNxt;
        end
    end

endmodule
